prio_encoder_8_3_arb: RTL and testbench

//   Sequential 8-to-3 priority encoder/arbiter; the inverse of the decoder_2_4 / mux_8_1 select path.

---
 rtl/prio_encoder_8_3_arb_pkg.sv | 32 +++
 rtl/prio_encoder_8_3_arb_enc.sv | 27 ++
 rtl/prio_encoder_8_3_arb.sv | 141 ++++++++++++++
 tb/tb_prio_encoder_8_3_arb.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_8_3_arb_pkg.sv
// Shared definitions for the 8-to-3 priority encoder/arbiter: sizes, FSM encoding
// and one-hot/index conversion helpers.
package prio_encoder_8_3_arb_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_encoder_8_3_arb_enc.sv
// Combinational wrap-around search: first set bit at or above (base+1) mod 8 wins.
// base=7 degenerates to a plain lowest-index-first search.
module prio_enc_8_3
    import prio_encoder_8_3_arb_pkg::*;
(
    input  logic [N-1:0]     in_vec,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pos = base + IDX_W'(i + 1);
            if (!any && in_vec[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_encoder_8_3_arb.sv
// Sequential 8-to-3 priority arbiter: sticky pending vector, two-state offer FSM,
// grant counter. Define ROUND_ROBIN_EN for round-robin instead of highest-index-first.
//
// Handshake: out_idx is offered while out_valid=1 and held stable until out_ready=1
// is seen at a rising edge; that edge is the transfer. out_ready while out_valid=0 is ignored.
module prio_encoder_8_3_arb
    import prio_encoder_8_3_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] grant_cnt,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    logic             accept;
    logic [N-1:0]     clr;
    logic [N-1:0]     enc_in;
    logic [IDX_W-1:0] enc_base;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic [IDX_W-1:0] sel_idx;

    assign accept = (state_q == ST_OFFER) && out_valid_q && out_ready;
    assign clr    = accept ? idx_to_onehot(out_idx_q) : '0;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_idx_q, last_idx_d;

    assign enc_in   = pending_q;
    assign enc_base = last_idx_q;
    assign sel_idx  = enc_idx;

    always_comb begin
        last_idx_d = last_idx_q;
        if (accept) begin
            last_idx_d = out_idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx_q <= IDX_W'(N - 1);
        end else begin
            last_idx_q <= last_idx_d;
        end
    end
`else
    // Bit-reversed input with base=7 turns the lowest-first search into highest-first.
    always_comb begin
        enc_in = '0;
        for (int i = 0; i < N; i++) begin
            enc_in[i] = pending_q[N-1-i];
        end
    end

    assign enc_base = IDX_W'(N - 1);
    assign sel_idx  = ~enc_idx;
`endif

    prio_enc_8_3 u_enc (
        .in_vec (enc_in),
        .base   (enc_base),
        .idx    (enc_idx),
        .any    (enc_any)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enc_any) state_d = ST_OFFER;
            ST_OFFER: if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next values; req is OR-ed last so a same-cycle re-request survives the clear.
    always_comb begin
        pending_d   = (pending_q & ~clr) | req;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        grant_cnt_d = grant_cnt_q;
        case (state_q)
            ST_IDLE: begin
                out_valid_d = 1'b0;
                if (enc_any) begin
                    out_idx_d   = sel_idx;
                    out_valid_d = 1'b1;
                end
            end
            ST_OFFER: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    grant_cnt_d = grant_cnt_q + 1'b1;
                end
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            grant_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign grant_cnt = grant_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prio_encoder_8_3_arb.sv
// Directed bench for prio_encoder_8_3_arb: reset, latency, fixed-priority drain,
// backpressure, set/clear collision, and round-robin when ROUND_ROBIN_EN is defined.
module tb_prio_encoder_8_3_arb;
    import prio_encoder_8_3_arb_pkg::*;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic [N-1:0]     pending;
    logic [CNT_W-1:0] grant_cnt;
    state_e           dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    prio_encoder_8_3_arb dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .pending   (pending),
        .grant_cnt (grant_cnt),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        tick();
        rst       = 1'b0;
    endtask

    // Wait (bounded) for an offer, check its index, then accept it (out_ready must be 1).
    task automatic take_grant(input string tag, input logic [IDX_W-1:0] exp);
        int n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_idx), 32'(exp));
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b0;

        // 1: reset overrides requests
        tick();
        tick();
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_idx",     32'(out_idx), 32'd0);
        check("rst_cnt",     32'(grant_cnt), 32'd0);
        check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        req = '0;

        // out_ready with nothing offered does nothing
        out_ready = 1'b1;
        tick();
        tick();
        check("idle_ready_valid", 32'(out_valid), 32'd0);
        check("idle_ready_cnt",   32'(grant_cnt), 32'd0);

        // 2: single request, two-edge latency
        req = 8'h20;
        tick();
        req = '0;
        check("single_pending", 32'(pending), 32'h20);
        check("single_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_idx",   32'(out_idx), 32'd5);
        check("single_state", 32'(dbg_state), 32'(ST_OFFER));
        tick();
        check("single_acc_valid",   32'(out_valid), 32'd0);
        check("single_acc_pending", 32'(pending), 32'h00);
        check("single_acc_cnt",     32'(grant_cnt), 32'd1);

`ifndef ROUND_ROBIN_EN
        // 3: fixed-priority drain 7,2,0 with a bubble between grants
        do_reset();
        out_ready = 1'b1;
        req = 8'h85;
        tick();
        req = '0;
        tick();
        check("drain_idx0", 32'(out_idx), 32'd7);
        check("drain_v0",   32'(out_valid), 32'd1);
        tick();
        check("drain_bubble0", 32'(out_valid), 32'd0);
        check("drain_pend0",   32'(pending), 32'h05);
        tick();
        check("drain_idx1", 32'(out_idx), 32'd2);
        check("drain_v1",   32'(out_valid), 32'd1);
        tick();
        check("drain_bubble1", 32'(out_valid), 32'd0);
        tick();
        check("drain_idx2", 32'(out_idx), 32'd0);
        check("drain_v2",   32'(out_valid), 32'd1);
        tick();
        check("drain_cnt",  32'(grant_cnt), 32'd3);
        check("drain_pend", 32'(pending), 32'h00);
        check("drain_end_valid", 32'(out_valid), 32'd0);

        // 4: backpressure holds idx 3 while a higher request arrives
        do_reset();
        req = 8'h08;
        tick();
        req = '0;
        tick();
        check("bp_idx_first", 32'(out_idx), 32'd3);
        req = 8'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            req = '0;
            check("bp_idx_hold",   32'(out_idx), 32'd3);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
        end
        check("bp_pending", 32'(pending), 32'h88);
        out_ready = 1'b1;
        tick();
        check("bp_acc_pending", 32'(pending), 32'h80);
        check("bp_acc_cnt",     32'(grant_cnt), 32'd1);
        take_grant("bp_next", 3'd7);

        // All eight requests drain 7..0
        do_reset();
        out_ready = 1'b1;
        req = 8'hFF;
        tick();
        req = '0;
        for (int i = 7; i >= 0; i--) begin
            take_grant("all8", IDX_W'(i));
        end
        check("all8_cnt",     32'(grant_cnt), 32'd8);
        check("all8_pending", 32'(pending), 32'h00);
`endif

        // 5: re-request in the accept cycle keeps the bit and re-offers it
        do_reset();
        req = 8'h10;
        tick();
        req = '0;
        tick();
        check("coll_idx", 32'(out_idx), 32'd4);
        out_ready = 1'b1;
        req = 8'h10;
        tick();
        req = '0;
        check("coll_pending", 32'(pending), 32'h10);
        check("coll_cnt",     32'(grant_cnt), 32'd1);
        take_grant("coll_reoffer", 3'd4);
        check("coll_end_pending", 32'(pending), 32'h00);
        check("coll_end_cnt",     32'(grant_cnt), 32'd2);

        // Mid-offer reset drops the offer and pending bits
        out_ready = 1'b0;
        req = 8'h42;
        tick();
        tick();
        check("mid_valid_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        check("mid_rst_valid",   32'(out_valid), 32'd0);
        check("mid_rst_pending", 32'(pending), 32'h00);
        check("mid_rst_cnt",     32'(grant_cnt), 32'd0);

`ifdef ROUND_ROBIN_EN
        // 6: round-robin alternation and counter wrap
        do_reset();
        out_ready = 1'b1;
        req = 8'h81;
        for (int g = 0; g < 256; g++) begin
            take_grant("rr_idx", (g % 2 == 0) ? 3'd0 : 3'd7);
        end
        check("rr_cnt_wrap", 32'(grant_cnt), 32'd0);
        req = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
